// File: rtl/grf_wport_arbiter_pkg.sv
// Shared widths, the zero-register constant and the write-queue entry layout.
package grf_wport_arbiter_pkg;
    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wq_entry_t;
endpackage

// File: rtl/grf_wq.sv
// Circular write queue with per-entry live bits, kill-by-address and two pending-lookup ports.
// Latency: enqueued entry is at the head next cycle; backpressure: caller must not enqueue when cnt==DEPTH.
module grf_wq
    import grf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq_vld,
    input  wq_entry_t         enq_dat,
    input  logic              deq_vld,
    input  logic              kill_vld,
    input  logic [REG_AW-1:0] kill_a3,
    input  logic [REG_AW-1:0] q_a1,
    input  logic [REG_AW-1:0] q_a2,
    output logic              head_vld,
    output wq_entry_t         head_dat,
    output logic [CW-1:0]     cnt,
    output logic              pend1,
    output logic              pend2
);
    wq_entry_t     mem_q [DEPTH];
    wq_entry_t     mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deq_fire;

    assign head_vld = (cnt_q != '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign cnt      = cnt_q;
    assign deq_fire = deq_vld && head_vld;

    // Kill only sees state from the start of the cycle, so the slot written
    // by a same-cycle enqueue is applied last and keeps live=1.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_vld && (mem_q[i].a3 == kill_a3)) begin
                mem_d[i].live = 1'b0;
            end
        end
        if (deq_fire) begin
            mem_d[rd_ptr_q].live = 1'b0;
            rd_ptr_d             = rd_ptr_q + PW'(1);
        end
        if (enq_vld) begin
            mem_d[wr_ptr_q] = enq_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(enq_vld) - CW'(deq_fire);
    end

    // Popped slots are cleared, so live=1 marks exactly the resident, unkilled entries.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].live && (mem_q[i].a3 == q_a1) && (q_a1 != REG_ZERO)) pend1 = 1'b1;
            if (mem_q[i].live && (mem_q[i].a3 == q_a2) && (q_a2 != REG_ZERO)) pend2 = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/grf_wport_arbiter.sv
// Shares the GRF write port: W has absolute priority, M results are queued and drained when W idles.
// Latency: W 0 cycles, M at least 1 cycle; backpressure: m_ready drops when the queue is full or in reset.
module grf_wport_arbiter
    import grf_wport_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_we,
    input  logic [REG_AW-1:0] w_a3,
    input  logic [DATA_W-1:0] w_wd,
    input  logic [DATA_W-1:0] w_pc,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [REG_AW-1:0] m_a3,
    input  logic [DATA_W-1:0] m_wd,
    input  logic [DATA_W-1:0] m_pc,
    output logic              grf_we,
    output logic [REG_AW-1:0] grf_a3,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc,
    input  logic [REG_AW-1:0] q_a1,
    input  logic [REG_AW-1:0] q_a2,
    output logic              pend1,
    output logic              pend2,
    output logic [CW-1:0]     wq_cnt
);
    logic      w_eff;
    logic      enq_vld;
    logic      deq_vld;
    logic      head_vld;
    wq_entry_t enq_dat;
    wq_entry_t head_dat;

    assign w_eff   = w_we && (w_a3 != REG_ZERO) && !reset;
    assign m_ready = (wq_cnt != CW'(DEPTH)) && !reset;
    // Writes to r0 complete the handshake but never occupy a slot.
    assign enq_vld = m_valid && m_ready && (m_a3 != REG_ZERO);
    assign enq_dat = '{live: 1'b1, a3: m_a3, wd: m_wd, pc: m_pc};
    assign deq_vld = head_vld && (!head_dat.live || !w_eff);

    grf_wq #(.DEPTH(DEPTH)) u_wq (
        .clk      (clk),
        .rst      (reset),
        .enq_vld  (enq_vld),
        .enq_dat  (enq_dat),
        .deq_vld  (deq_vld),
        .kill_vld (w_eff),
        .kill_a3  (w_a3),
        .q_a1     (q_a1),
        .q_a2     (q_a2),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .cnt      (wq_cnt),
        .pend1    (pend1),
        .pend2    (pend2)
    );

    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = '0;
        if (w_eff) begin
            grf_we = 1'b1;
            grf_a3 = w_a3;
            grf_wd = w_wd;
            grf_pc = w_pc;
        end else if (head_vld && head_dat.live) begin
            grf_we = 1'b1;
            grf_a3 = head_dat.a3;
            grf_wd = head_dat.wd;
            grf_pc = head_dat.pc;
        end
    end
endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed steps plus a per-cycle reference queue that predicts every GRF write and status output.
module tb_grf_wport_arbiter;
    localparam int DEPTH = 2;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk, reset;
    logic          w_we, m_valid, m_ready, grf_we, pend1, pend2;
    logic [4:0]    w_a3, m_a3, grf_a3, q_a1, q_a2;
    logic [31:0]   w_wd, w_pc, m_wd, m_pc, grf_wd, grf_pc;
    logic [CW-1:0] wq_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        live;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ment_t;
    ment_t model[$];

    grf_wport_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc),
        .m_valid(m_valid), .m_ready(m_ready), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .q_a1(q_a1), .q_a2(q_a2), .pend1(pend1), .pend2(pend2), .wq_cnt(wq_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: predict this cycle's outputs, then retire/kill/accept.
    always @(negedge clk) begin
        logic        ew, weff, pop, rdy;
        logic [4:0]  ea;
        logic [31:0] ed, ep;
        logic        p1, p2;
        if (reset) begin
            model.delete();
            chk("rst_mon_we", 64'(grf_we), 64'd0);
            chk("rst_mon_wd", 64'(grf_wd), 64'd0);
            chk("rst_mon_cnt", 64'(wq_cnt), 64'd0);
            chk("rst_mon_rdy", 64'(m_ready), 64'd0);
        end else begin
            weff = w_we && (w_a3 != 5'd0);
            ew = 1'b0; ea = '0; ed = '0; ep = '0;
            if (weff) begin
                ew = 1'b1; ea = w_a3; ed = w_wd; ep = w_pc;
            end else if (model.size() > 0 && model[0].live) begin
                ew = 1'b1; ea = model[0].a3; ed = model[0].wd; ep = model[0].pc;
            end
            p1 = 1'b0; p2 = 1'b0;
            foreach (model[i]) begin
                if (model[i].live && model[i].a3 == q_a1 && q_a1 != 5'd0) p1 = 1'b1;
                if (model[i].live && model[i].a3 == q_a2 && q_a2 != 5'd0) p2 = 1'b1;
            end
            rdy = (model.size() < DEPTH);
            chk("mon_we", 64'(grf_we), 64'(ew));
            chk("mon_a3", 64'(grf_a3), 64'(ea));
            chk("mon_wd", 64'(grf_wd), 64'(ed));
            chk("mon_pc", 64'(grf_pc), 64'(ep));
            chk("mon_cnt", 64'(wq_cnt), 64'(model.size()));
            chk("mon_rdy", 64'(m_ready), 64'(rdy));
            chk("mon_pend1", 64'(pend1), 64'(p1));
            chk("mon_pend2", 64'(pend2), 64'(p2));
            pop = (model.size() > 0) && (!model[0].live || !weff);
            if (weff) begin
                foreach (model[i]) if (model[i].a3 == w_a3) model[i].live = 1'b0;
            end
            if (pop) void'(model.pop_front());
            if (m_valid && rdy && m_a3 != 5'd0)
                model.push_back('{live: 1'b1, a3: m_a3, wd: m_wd, pc: m_pc});
        end
    end

    initial begin
        reset = 1'b1;
        w_we = 0; w_a3 = 0; w_wd = 0; w_pc = 0;
        m_valid = 0; m_a3 = 0; m_wd = 0; m_pc = 0;
        q_a1 = 0; q_a2 = 0;
        @(negedge clk);
        chk("rst_cnt", 64'(wq_cnt), 64'd0);
        chk("rst_rdy", 64'(m_ready), 64'd0);
        chk("rst_we", 64'(grf_we), 64'd0);
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", 64'(m_ready), 64'd1);

        // W alone, then W to r0
        tick(); w_we = 1; w_a3 = 5; w_wd = 32'h1234; w_pc = 32'h100;
        @(negedge clk);
        chk("t1_we", 64'(grf_we), 64'd1);
        chk("t1_a3", 64'(grf_a3), 64'd5);
        chk("t1_wd", 64'(grf_wd), 64'h1234);
        chk("t1_pc", 64'(grf_pc), 64'h100);
        tick(); w_a3 = 0;
        @(negedge clk);
        chk("t1_r0_we", 64'(grf_we), 64'd0);

        // M alone: write one cycle after acceptance
        tick(); w_we = 0; m_valid = 1; m_a3 = 8; m_wd = 32'hAA; m_pc = 32'h200; q_a1 = 8;
        @(negedge clk);
        chk("t2_rdy", 64'(m_ready), 64'd1);
        chk("t2_pend_pre", 64'(pend1), 64'd0);
        tick(); m_valid = 0;
        @(negedge clk);
        chk("t2_pend", 64'(pend1), 64'd1);
        chk("t2_we", 64'(grf_we), 64'd1);
        chk("t2_a3", 64'(grf_a3), 64'd8);
        chk("t2_wd", 64'(grf_wd), 64'hAA);
        tick();
        @(negedge clk);
        chk("t2_cnt", 64'(wq_cnt), 64'd0);

        // Queue fills behind continuous W, then drains in order
        tick(); w_we = 1; w_a3 = 3; w_wd = 32'h30; m_valid = 1; m_a3 = 10; m_wd = 32'hB0; m_pc = 32'h300;
        @(negedge clk);
        chk("t3_rdy0", 64'(m_ready), 64'd1);
        tick(); w_wd = 32'h31; m_a3 = 11; m_wd = 32'hB1;
        @(negedge clk);
        chk("t3_rdy1", 64'(m_ready), 64'd1);
        chk("t3_w_a3", 64'(grf_a3), 64'd3);
        tick(); w_wd = 32'h32; m_a3 = 12; m_wd = 32'hB2;
        @(negedge clk);
        chk("t3_full_rdy", 64'(m_ready), 64'd0);
        chk("t3_full_cnt", 64'(wq_cnt), 64'd2);
        tick(); w_wd = 32'h33;
        @(negedge clk);
        chk("t3_hold_rdy", 64'(m_ready), 64'd0);
        tick(); w_we = 0;
        @(negedge clk);
        chk("t3_d0_a3", 64'(grf_a3), 64'd10);
        chk("t3_d0_wd", 64'(grf_wd), 64'hB0);
        tick();
        @(negedge clk);
        chk("t3_d1_a3", 64'(grf_a3), 64'd11);
        chk("t3_d1_rdy", 64'(m_ready), 64'd1);
        tick(); m_valid = 0;
        @(negedge clk);
        chk("t3_d2_a3", 64'(grf_a3), 64'd12);
        chk("t3_d2_wd", 64'(grf_wd), 64'hB2);
        tick();
        @(negedge clk);
        chk("t3_cnt_end", 64'(wq_cnt), 64'd0);

        // Queued write to r9 killed by a newer W write to r9
        tick(); w_we = 1; w_a3 = 4; w_wd = 32'h44; m_valid = 1; m_a3 = 9; m_wd = 32'hC9; q_a2 = 9;
        tick(); m_valid = 0; w_a3 = 9; w_wd = 32'h77; w_pc = 32'h400;
        @(negedge clk);
        chk("t4_pend", 64'(pend2), 64'd1);
        chk("t4_we", 64'(grf_we), 64'd1);
        chk("t4_wd", 64'(grf_wd), 64'h77);
        tick(); w_we = 0;
        @(negedge clk);
        chk("t4_pend_drop", 64'(pend2), 64'd0);
        chk("t4_killed_cnt", 64'(wq_cnt), 64'd1);
        chk("t4_killed_we", 64'(grf_we), 64'd0);
        tick();
        @(negedge clk);
        chk("t4_cnt", 64'(wq_cnt), 64'd0);

        // M to r0 is accepted and dropped
        tick(); m_valid = 1; m_a3 = 0; m_wd = 32'hDD;
        @(negedge clk);
        chk("t5_rdy", 64'(m_ready), 64'd1);
        tick(); m_valid = 0;
        @(negedge clk);
        chk("t5_cnt", 64'(wq_cnt), 64'd0);
        chk("t5_we", 64'(grf_we), 64'd0);

        // Async reset with two live entries
        tick(); w_we = 1; w_a3 = 3; m_valid = 1; m_a3 = 13; m_wd = 32'hD13; q_a1 = 13; q_a2 = 14;
        tick(); m_a3 = 14; m_wd = 32'hD14;
        tick(); m_valid = 0;
        chk("t6_cnt", 64'(wq_cnt), 64'd2);
        chk("t6_p1", 64'(pend1), 64'd1);
        chk("t6_p2", 64'(pend2), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_cnt", 64'(wq_cnt), 64'd0);
        chk("t6_rst_rdy", 64'(m_ready), 64'd0);
        chk("t6_rst_p1", 64'(pend1), 64'd0);
        chk("t6_rst_p2", 64'(pend2), 64'd0);
        chk("t6_rst_we", 64'(grf_we), 64'd0);
        chk("t6_rst_wd", 64'(grf_wd), 64'd0);
        w_we = 0;
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("t6_rdy_after", 64'(m_ready), 64'd1);
        chk("t6_cnt_after", 64'(wq_cnt), 64'd0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/grf_wport_arbiter.md
# grf_wport_arbiter

Shares the single GRF write port between two writers. The pipeline writeback stage (W) has absolute priority and is never stalled. A multi-cycle result unit (M, e.g. the mult/div or coprocessor return path) uses a valid/ready handshake and writes through a small write queue. The block sits between W/M and the GRF write inputs (WE, A3, WD, PC). It also drives per-register pending flags so decode can stall on queued M results.

## Interface
- DEPTH, 2, write-queue entries (power of two, ≥2)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- w_we  in  1  W-stage write request
- w_a3  in  5  W destination register
- w_wd  in  32  W write data
- w_pc  in  32  W instruction PC (forwarded for the GRF write log)
- m_valid  in  1  M result offered
- m_ready  out  1  queue can accept M result
- m_a3  in  5  M destination register
- m_wd  in  32  M result data
- m_pc  in  32  M instruction PC
- grf_we  out  1  to GRF WE
- grf_a3  out  5  to GRF A3
- grf_wd  out  32  to GRF WD
- grf_pc  out  32  to GRF PC
- q_a1  in  5  decode lookup address 1
- q_a2  in  5  decode lookup address 2
- pend1  out  1  live queued write to q_a1
- pend2  out  1  live queued write to q_a2
- wq_cnt  out  $clog2(DEPTH)+1  queue occupancy, including killed entries

## Operation
- W write is effective iff w_we=1 and w_a3≠0. An effective W write drives grf_* directly: grf_we=1, grf_a3/wd/pc = w_*.
- M handshake: a transfer occurs when m_valid=1 and m_ready=1. m_ready = (wq_cnt≠DEPTH) and reset=0. There is no bypass: every accepted M result goes through the queue.
- M transfer with m_a3=0 is accepted and discarded (not enqueued).
- Queue entry holds {live, a3, wd, pc}. Enqueued entries have live=1.
- Kill: an effective W write to register R clears live on every entry resident at the start of the cycle whose a3=R. W is newer and must not be overwritten later. An entry enqueued in that same cycle is not killed.
- Dequeue of the head entry, evaluated per cycle when the queue is non-empty:
  - Head not live: pop; grf_we is not driven by the head.
  - Head live and no effective W write: pop; grf_we=1, grf_a3/wd/pc = head fields.
  - Head live and effective W write: hold; W wins.
- Enqueue and pop in the same cycle are both permitted; wq_cnt is unchanged.
- pendN = OR over entries of (live and a3=q_aN and q_aN≠0). Killed entries never assert pend.
- Idle (no effective W write, head absent or killed): grf_we=0. grf_a3/wd/pc = 0 whenever grf_we=0.

## Timing
- W path latency 0: combinational to grf_*. The GRF commits at the same posedge.
- M path minimum latency 1: accepted at posedge k, written at posedge k+1 if W is idle in cycle k+1.
- m_ready, pend*, wq_cnt are functions of registered state (and q_a*) only. There is no combinational path from m_valid to m_ready.
- Reset (async, any time, including mid-transfer): queue emptied, all live=0, wq_cnt=0, m_ready=0, pend*=0, grf_we=0, grf_a3/wd/pc=0. An M transfer coinciding with reset is lost.
- Pointers wrap modulo DEPTH; full is wq_cnt=DEPTH, empty is wq_cnt=0.

## Structure
- Shared package: REG_ZERO (5'd0), REG_AW=5, DATA_W=32, and the queue entry struct {live, a3, wd, pc}.
- One sub-module: grf_wq. It is a circular queue with per-entry live bits, a kill-by-address input, and two address-match ports. The top level holds only the priority mux and the handshake logic.

## Test plan
- W only, w_we=1, w_a3=5, w_wd=0x1234 → grf_we=1, grf_a3=5, grf_wd=0x1234 in the same cycle. With w_a3=0, grf_we=0.
- M alone, m_a3=8, m_wd=0xAA accepted at cycle 0 → pend for 8 asserted in cycle 1. Cycle 1 shows grf_we=1, grf_a3=8, grf_wd=0xAA. wq_cnt back to 0 in cycle 2.
- DEPTH=2: three back-to-back M offers while W writes continuously → m_ready=0 after two accepts. The third is held until W idles, then the writes drain in order.
- Queued M write to reg 9, then W writes reg 9 = 0x77 → entry killed and pend for 9 drops. The killed entry pops with grf_we=0. The GRF value of reg 9 stays 0x77.
- M offer with m_a3=0 → accepted, wq_cnt unchanged, no GRF write.
- Reset asserted with 2 live entries → immediately wq_cnt=0, m_ready=0, pend*=0, grf_we=0. After release, m_ready=1.
